noc_flit_tx: RTL and testbench
==============================

Name: noc_flit_tx

Overview:
- Credit-based flit transmitter: accepts AXI-Stream beats and drives one router input port (data/dest/is_tail/send, with credit return).
- Serializes each TDATA beat into SERIALIZATION_FACTOR flits and never sends without a downstream credit.
- Placement: between a user endpoint or a test traffic source and a router input buffer of FLIT_BUFFER_DEPTH entries, in the single-clock NoC domain.

Parameters:
- TDATA_WIDTH, 128, AXIS beat width.
- TDEST_WIDTH, 4, AXIS destination width.
- TID_WIDTH, 2, AXIS id width.
- SERIALIZATION_FACTOR, 2, flits per beat; must be ≥1 and divide TDATA_WIDTH.
- FLIT_BUFFER_DEPTH, 8, downstream input buffer depth; this is the initial credit count.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, flit destination width.
- FLIT_WIDTH, TDATA_WIDTH/SERIALIZATION_FACTOR, flit payload width.

Ports:
- clk  in  1  NoC clock; all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset.
- axis_tvalid  in  1  beat valid.
- axis_tready  out  1  beat accepted when tvalid&&tready.
- axis_tdata  in  TDATA_WIDTH  beat payload.
- axis_tlast  in  1  last beat of packet.
- axis_tid  in  TID_WIDTH  packet id.
- axis_tdest  in  TDEST_WIDTH  destination endpoint.
- data_out  out  FLIT_WIDTH  flit payload.
- dest_out  out  DEST_WIDTH  flit destination, {tid,tdest}.
- is_tail_out  out  1  flit is the last flit of its packet.
- send_out  out  1  flit valid; exactly one credit consumed per send.
- credit_in  in  1  one downstream buffer slot freed.
- credit_count  out  $clog2(FLIT_BUFFER_DEPTH+1)  current credits, for debug.
- busy  out  1  a beat is held or being sent.
- err_credit_ovf  out  1  sticky flag: credit_in was received while the count was already FLIT_BUFFER_DEPTH.

Behaviour:
- Reset values (async assert, sync release): credit_count=FLIT_BUFFER_DEPTH, all other outputs 0, FSM=IDLE, chunk index idx=0.
- FSM states:
  - IDLE: axis_tready=1. On handshake, latch tdata, tlast, {tid,tdest} into the hold register, set idx=0, go to SEND.
  - SEND: if credit_count>0, emit chunk idx on the next edge (registered outputs) and increment idx.
  - Leaving SEND: when chunk SERIALIZATION_FACTOR-1 is emitted, return to IDLE; if a new beat is handshaked in that same cycle, stay in SEND with idx=0.
- axis_tready = (state==IDLE) || (state==SEND && credit_count>0 && idx==SERIALIZATION_FACTOR-1). This gives back-to-back beats with no bubble.
- Chunk order: LSB first. Chunk k = tdata[k*FLIT_WIDTH +: FLIT_WIDTH].
- dest_out carries {tid,tdest} on every flit.
- is_tail_out = held tlast && idx==SERIALIZATION_FACTOR-1.
- send_out is a one-cycle pulse per flit. Outputs other than send_out hold their last value when send_out=0.
- Latency: beat handshake at edge N gives first send_out=1 in the cycle after edge N+1. Peak rate is 1 flit per cycle.
- Credit gating uses the registered credit_count only. A credit_in arriving in the same cycle does not enable a send while count is 0; it becomes usable one cycle later.
- Credit arithmetic:
  - next = count + credit_in − send.
  - Simultaneous credit_in and send: count unchanged.
  - count never goes below 0, guaranteed by gating.
  - credit_in at count==FLIT_BUFFER_DEPTH with no send: count saturates, err_credit_ovf sets and stays set until reset.
- Credit exhaustion mid-beat: stall between chunks, keep idx and the hold register, axis_tready=0. Resume on the first cycle count>0.
- SERIALIZATION_FACTOR=1: every beat is one flit; is_tail_out = tlast.
- Reset mid-packet: the partial beat is discarded, credits return to FLIT_BUFFER_DEPTH. The downstream block must be reset together with this block.
- busy = (state==SEND).

Decomposition:
- Package noc_tx_pkg: FSM enum (IDLE, SEND), function for the credit counter width ($clog2(FLIT_BUFFER_DEPTH+1)), localparam IDX_WIDTH = max(1,$clog2(SERIALIZATION_FACTOR)).
- Sub-module noc_credit_counter holds the counter, saturation and overflow flag. Parameter DEPTH; ports clk, rst_n, credit_in, consume, count, can_send, err_ovf.
- Top level holds the FSM, hold register and chunk mux.

Test Plan:
- Single beat, default params: tdata=0x1111..._2222..., tid=1, tdest=5, tlast=1 → two flits on consecutive cycles.
  - Flit 0: data=0x2222...; flit 1: data=0x1111..., is_tail=1.
  - dest_out=0x15 on both; credit_count goes 8→6.
- No credit return, 5 back-to-back beats → exactly 8 flits sent.
  - After the 8th send: send_out stays 0, axis_tready=0, credit_count=0.
  - One credit_in pulse → the 9th flit appears 2 cycles later.
- Simultaneous credit_in and send on every cycle with count=3 → count stays 3 and sustained 1 flit/cycle throughput.
- credit_in pulse with count=8 and idle → count stays 8, err_credit_ovf=1 and remains 1 until rst_n=0.
- Assert rst_n=0 after flit 0 of a beat → outputs 0 immediately (async).
  - After release: credit_count=8, axis_tready=1, and flit 1 of the old beat is never sent.
- SERIALIZATION_FACTOR=1, 3-beat packet with tlast on beat 3 → 3 flits, is_tail only on the 3rd, no idle cycles between flits.

Source files
------------

// File: rtl/noc_tx_pkg.sv
// Shared types and sizing helpers for the credit-based NoC flit transmitter.
package noc_tx_pkg;

  // Transmitter control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Width needed to hold a credit count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of the chunk index. The minimum is one bit so the index
  // still exists when a beat is a single flit.
  function automatic int idx_width(input int sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker. It starts full, decrements on every send and
// increments on every returned credit. A credit that arrives while the
// count is already full is dropped and sets a sticky overflow flag.
module noc_credit_counter
  import noc_tx_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          credit_in,
  input  logic          consume,
  output logic [CW-1:0] count,
  output logic          can_send,
  output logic          err_ovf
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Sending is gated only by the registered count. A credit arriving this
  // cycle becomes usable on the next cycle.
  assign can_send = (count != '0);

  // Update the count. A simultaneous return and consume cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (!rst_n) begin
      count   <= FULL;
      err_ovf <= 1'b0;
    end else begin
      unique case ({credit_in, consume})
        2'b10: begin
          if (count == FULL) err_ovf <= 1'b1;
          else               count   <= count + 1'b1;
        end
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noc_flit_tx.sv
// Credit-based flit transmitter. It accepts AXI-Stream beats, splits each
// beat LSB-first into SERIALIZATION_FACTOR flits and drives a router input
// port. A flit is never sent unless a downstream credit is held.
module noc_flit_tx
  import noc_tx_pkg::*;
#(
  parameter  int TDATA_WIDTH          = 128,
  parameter  int TDEST_WIDTH          = 4,
  parameter  int TID_WIDTH            = 2,
  parameter  int SERIALIZATION_FACTOR = 2,
  parameter  int FLIT_BUFFER_DEPTH    = 8,
  localparam int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  localparam int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   axis_tvalid,
  output logic                                   axis_tready,
  input  logic [TDATA_WIDTH-1:0]                 axis_tdata,
  input  logic                                   axis_tlast,
  input  logic [TID_WIDTH-1:0]                   axis_tid,
  input  logic [TDEST_WIDTH-1:0]                 axis_tdest,
  output logic [FLIT_WIDTH-1:0]                  data_out,
  output logic [DEST_WIDTH-1:0]                  dest_out,
  output logic                                   is_tail_out,
  output logic                                   send_out,
  input  logic                                   credit_in,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credit_count,
  output logic                                   busy,
  output logic                                   err_credit_ovf
);

  localparam int                  IDX_WIDTH = idx_width(SERIALIZATION_FACTOR);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);

  tx_state_e                 state;
  logic [IDX_WIDTH-1:0]      idx;
  logic [TDATA_WIDTH-1:0]    hold_data;
  logic                      hold_last;
  logic [DEST_WIDTH-1:0]     hold_dest;

  logic                      can_send;
  logic                      fire;
  logic                      last_chunk;
  logic                      handshake;
  logic [FLIT_WIDTH-1:0]     chunk;

  // Credit bookkeeping. One credit is consumed for every flit emitted.
  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .credit_in (credit_in),
    .consume   (fire),
    .count     (credit_count),
    .can_send  (can_send),
    .err_ovf   (err_credit_ovf)
  );

  assign fire        = (state == SEND) && can_send;
  assign last_chunk  = (idx == LAST_IDX);
  // A new beat can be taken while the final chunk of the current one leaves,
  // so back-to-back beats stream without a bubble.
  assign axis_tready = (state == IDLE) || (fire && last_chunk);
  assign handshake   = axis_tvalid && axis_tready;
  assign busy        = (state == SEND);

  // Select the chunk currently addressed by idx, least significant first.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path
    // leaves it unassigned and a latch is inferred.
    chunk = '0;
    chunk = hold_data[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Capture each accepted beat into the hold register.
  // NOTE: the hold register is deliberately not reset; it is only read while
  // state==SEND, which requires a capture first, so a reset would only add
  // load on the reset tree.
  always_ff @(posedge clk) begin
    if (handshake) begin
      hold_data <= axis_tdata;
      hold_last <= axis_tlast;
      hold_dest <= {axis_tid, axis_tdest};
    end
  end

  // Control FSM: walk the chunk index while credits allow, rearm on a new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (handshake) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (fire) begin
            if (last_chunk) begin
              idx   <= '0;
              state <= handshake ? SEND : IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Registered flit outputs. Payload fields hold between sends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= fire;
      if (fire) begin
        data_out    <= chunk;
        dest_out    <= hold_dest;
        is_tail_out <= hold_last && last_chunk;
      end
    end
  end

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed bench for noc_flit_tx: a default two-flit-per-beat instance and a
// one-flit-per-beat instance, with hand-computed expected values.
module tb_noc_flit_tx;

  logic clk;
  logic rst_n;

  // Default-parameter instance (128-bit beats, 2 flits per beat).
  logic          a_tvalid;
  logic          a_tready;
  logic [127:0]  a_tdata;
  logic          a_tlast;
  logic [1:0]    a_tid;
  logic [3:0]    a_tdest;
  logic [63:0]   a_data;
  logic [5:0]    a_dest;
  logic          a_tail;
  logic          a_send;
  logic          a_credit;
  logic [3:0]    a_count;
  logic          a_busy;
  logic          a_err;

  // Single-flit instance (32-bit beats, 1 flit per beat).
  logic          b_tvalid;
  logic          b_tready;
  logic [31:0]   b_tdata;
  logic          b_tlast;
  logic [1:0]    b_tid;
  logic [3:0]    b_tdest;
  logic [31:0]   b_data;
  logic [5:0]    b_dest;
  logic          b_tail;
  logic          b_send;
  logic          b_credit;
  logic [3:0]    b_count;
  logic          b_busy;
  logic          b_err;

  int total = 0;
  int bad   = 0;

  noc_flit_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axis_tvalid    (a_tvalid),
    .axis_tready    (a_tready),
    .axis_tdata     (a_tdata),
    .axis_tlast     (a_tlast),
    .axis_tid       (a_tid),
    .axis_tdest     (a_tdest),
    .data_out       (a_data),
    .dest_out       (a_dest),
    .is_tail_out    (a_tail),
    .send_out       (a_send),
    .credit_in      (a_credit),
    .credit_count   (a_count),
    .busy           (a_busy),
    .err_credit_ovf (a_err)
  );

  noc_flit_tx #(
    .TDATA_WIDTH          (32),
    .SERIALIZATION_FACTOR (1)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .axis_tvalid    (b_tvalid),
    .axis_tready    (b_tready),
    .axis_tdata     (b_tdata),
    .axis_tlast     (b_tlast),
    .axis_tid       (b_tid),
    .axis_tdest     (b_tdest),
    .data_out       (b_data),
    .dest_out       (b_dest),
    .is_tail_out    (b_tail),
    .send_out       (b_send),
    .credit_in      (b_credit),
    .credit_count   (b_count),
    .busy           (b_busy),
    .err_credit_ovf (b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    a_tvalid = 1'b0; a_tdata = '0; a_tlast = 1'b0; a_tid = '0; a_tdest = '0; a_credit = 1'b0;
    b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0; b_tid = '0; b_tdest = '0; b_credit = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [127:0] beat_data(input int b);
    logic [63:0] lo;
    logic [63:0] hi;
    lo = 64'hA0 + 64'(b);
    hi = 64'hB0 + 64'(b);
    return {hi, lo};
  endfunction

  initial begin
    int sends;
    int beat;
    logic hs;
    logic [127:0] exp_beat;
    logic seen_send;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_count", 128'(a_count), 128'd8);
    check("rst_send", 128'(a_send), 128'd0);
    check("rst_busy", 128'(a_busy), 128'd0);
    check("rst_err", 128'(a_err), 128'd0);
    check("rst_tready", 128'(a_tready), 128'd1);

    // ---------------- single beat ----------------
    a_tvalid = 1'b1;
    a_tdata  = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    a_tlast  = 1'b1;
    a_tid    = 2'd1;
    a_tdest  = 4'd5;
    step();                                 // handshake edge
    a_tvalid = 1'b0;
    check("s_latency_gap", 128'(a_send), 128'd0);
    check("s_busy", 128'(a_busy), 128'd1);
    step();
    check("s_f0_send", 128'(a_send), 128'd1);
    check("s_f0_data", 128'(a_data), 128'h2222_2222_2222_2222);
    check("s_f0_dest", 128'(a_dest), 128'h15);
    check("s_f0_tail", 128'(a_tail), 128'd0);
    check("s_f0_count", 128'(a_count), 128'd7);
    step();
    check("s_f1_send", 128'(a_send), 128'd1);
    check("s_f1_data", 128'(a_data), 128'h1111_1111_1111_1111);
    check("s_f1_dest", 128'(a_dest), 128'h15);
    check("s_f1_tail", 128'(a_tail), 128'd1);
    check("s_f1_count", 128'(a_count), 128'd6);
    step();
    check("s_after_send", 128'(a_send), 128'd0);
    check("s_after_hold", 128'(a_data), 128'h1111_1111_1111_1111);
    check("s_after_busy", 128'(a_busy), 128'd0);

    // ---------------- credit exhaustion ----------------
    do_reset();
    beat     = 0;
    sends    = 0;
    a_tvalid = 1'b1;
    a_tdata  = beat_data(0);
    a_tlast  = 1'b0;
    a_tid    = 2'd2;
    a_tdest  = 4'd3;
    for (int cyc = 0; cyc < 30; cyc++) begin
      hs = a_tvalid && a_tready;
      step();
      if (a_send) begin
        exp_beat = beat_data(sends / 2);
        check($sformatf("ex_flit%0d", sends), 128'(a_data),
              (sends % 2 == 0) ? 128'(exp_beat[63:0]) : 128'(exp_beat[127:64]));
        sends++;
      end
      if (hs) begin
        beat++;
        if (beat < 5) begin
          a_tdata = beat_data(beat);
          a_tlast = (beat == 4);
        end else begin
          a_tvalid = 1'b0;
        end
      end
    end
    check("ex_sends", 128'(sends), 128'd8);
    check("ex_beats", 128'(beat), 128'd5);
    check("ex_send_low", 128'(a_send), 128'd0);
    check("ex_tready", 128'(a_tready), 128'd0);
    check("ex_count", 128'(a_count), 128'd0);
    check("ex_busy", 128'(a_busy), 128'd1);
    a_credit = 1'b1;
    step();                                 // credit lands in the counter
    a_credit = 1'b0;
    check("ex_cr_count", 128'(a_count), 128'd1);
    check("ex_cr_nosend", 128'(a_send), 128'd0);
    step();
    check("ex_9th_send", 128'(a_send), 128'd1);
    check("ex_9th_data", 128'(a_data), 128'hA4);
    check("ex_9th_count", 128'(a_count), 128'd0);

    // ---------------- simultaneous credit and send ----------------
    do_reset();
    beat     = 0;
    a_tvalid = 1'b1;
    a_tdata  = beat_data(0);
    a_tlast  = 1'b0;
    for (int cyc = 0; cyc < 20 && a_count != 4'd3; cyc++) begin
      hs = a_tvalid && a_tready;
      step();
      if (hs) begin
        beat++;
        a_tdata = beat_data(beat);
      end
    end
    check("sim_reach3", 128'(a_count), 128'd3);
    a_credit = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      hs = a_tvalid && a_tready;
      step();
      check($sformatf("sim_send%0d", cyc), 128'(a_send), 128'd1);
      check($sformatf("sim_count%0d", cyc), 128'(a_count), 128'd3);
      if (hs) begin
        beat++;
        a_tdata = beat_data(beat);
      end
    end
    a_credit = 1'b0;
    a_tvalid = 1'b0;

    // ---------------- credit overflow ----------------
    do_reset();
    a_credit = 1'b1;
    step();
    a_credit = 1'b0;
    check("ovf_count", 128'(a_count), 128'd8);
    check("ovf_flag", 128'(a_err), 128'd1);
    repeat (3) step();
    check("ovf_sticky", 128'(a_err), 128'd1);
    rst_n = 1'b0;
    #1;
    check("ovf_cleared", 128'(a_err), 128'd0);
    rst_n = 1'b1;
    step();

    // ---------------- reset mid-beat ----------------
    do_reset();
    a_tvalid = 1'b1;
    a_tdata  = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    a_tlast  = 1'b1;
    step();
    a_tvalid = 1'b0;
    step();
    check("mr_f0_send", 128'(a_send), 128'd1);
    check("mr_f0_data", 128'(a_data), 128'h4444_4444_4444_4444);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_send", 128'(a_send), 128'd0);
    check("mr_async_data", 128'(a_data), 128'd0);
    check("mr_async_count", 128'(a_count), 128'd8);
    check("mr_async_busy", 128'(a_busy), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_rel_count", 128'(a_count), 128'd8);
    check("mr_rel_tready", 128'(a_tready), 128'd1);
    seen_send = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (a_send) seen_send = 1'b1;
    end
    check("mr_no_stale_flit", 128'(seen_send), 128'd0);

    // ---------------- one flit per beat ----------------
    do_reset();
    b_tid    = 2'd3;
    b_tdest  = 4'd9;
    b_tvalid = 1'b1;
    b_tdata  = 32'hC0DE_0001;
    b_tlast  = 1'b0;
    step();                                 // beat 0 accepted
    b_tdata = 32'hC0DE_0002;
    step();                                 // beat 1 accepted, flit 0 out
    check("sf1_f0_send", 128'(b_send), 128'd1);
    check("sf1_f0_data", 128'(b_data), 128'hC0DE_0001);
    check("sf1_f0_tail", 128'(b_tail), 128'd0);
    check("sf1_f0_dest", 128'(b_dest), 128'h39);
    b_tdata = 32'hC0DE_0003;
    b_tlast = 1'b1;
    step();                                 // beat 2 accepted, flit 1 out
    b_tvalid = 1'b0;
    b_tlast  = 1'b0;
    check("sf1_f1_send", 128'(b_send), 128'd1);
    check("sf1_f1_data", 128'(b_data), 128'hC0DE_0002);
    check("sf1_f1_tail", 128'(b_tail), 128'd0);
    step();
    check("sf1_f2_send", 128'(b_send), 128'd1);
    check("sf1_f2_data", 128'(b_data), 128'hC0DE_0003);
    check("sf1_f2_tail", 128'(b_tail), 128'd1);
    step();
    check("sf1_idle_send", 128'(b_send), 128'd0);
    check("sf1_count", 128'(b_count), 128'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
